md_seq_ctrl: RTL and testbench

- Multiply/divide sequencer for the P6 five-stage pipeline.
- Accepts E-stage multiply/divide/move-to ops, latches operands and holds the result for a fixed latency, then commits HI/LO.
- Drives `start`/`busy` into the F/D pipeline register enable, plus `md_stall` for the hazard unit.
- Sits beside the E-stage ALU; HI/LO feed the mfhi/mflo result mux.

---
 rtl/md_pkg.sv | 32 +++
 rtl/md_seq_ctrl_if.sv | 26 ++
 rtl/md_latency_cnt.sv | 27 ++
 rtl/md_seq_ctrl.sv | 111 +++++++++++
 tb/tb_md_seq_ctrl.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: opcode encoding, counter width, start decode.
// Optional multiply-accumulate opcodes are enabled by defining MDU_MADD_EN.
package md_pkg;

   localparam int MD_CNT_W = 4;

   typedef enum logic [3:0] {
      MD_NONE  = 4'd0,
      MD_MULT  = 4'd1,
      MD_MULTU = 4'd2,
      MD_DIV   = 4'd3,
      MD_DIVU  = 4'd4,
      MD_MTHI  = 4'd5,
      MD_MTLO  = 4'd6,
      MD_MADD  = 4'd7,
      MD_MADDU = 4'd8,
      MD_MSUB  = 4'd9,
      MD_MSUBU = 4'd10
   } md_op_t;

   // Opcodes that occupy the unit for a latency period.
   function automatic logic is_md_start(input logic [3:0] op);
      case (op)
         MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: return 1'b1;
`ifdef MDU_MADD_EN
         MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: return 1'b1;
`endif
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/md_seq_ctrl_if.sv
// E-stage request, D-stage hazard input and HI/LO results of the multiply/divide sequencer.
// The slave modport is the sequencer side; master is the pipeline side.
interface md_seq_ctrl_if;
   import md_pkg::*;

   logic        e_valid;
   md_op_t      md_op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        d_uses_md;
   logic        start;
   logic        busy;
   logic        md_stall;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output e_valid, md_op, rs_val, rt_val, d_uses_md,
      input  start, busy, md_stall, hi, lo
   );

   modport slave (
      input  e_valid, md_op, rs_val, rt_val, d_uses_md,
      output start, busy, md_stall, hi, lo
   );
endinterface

// File: rtl/md_latency_cnt.sv
// Latency down-counter: busy while non-zero, done flags the edge on which it reaches zero.
module md_latency_cnt
   import md_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                load,
   input  logic [MD_CNT_W-1:0] load_val,
   output logic                busy,
   output logic                done
);

   logic [MD_CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign busy = (cnt != '0);
   assign done = (cnt == MD_CNT_W'(1));

endmodule

// File: rtl/md_seq_ctrl.sv
// Multiply/divide sequencer: latches a 64-bit result at start, commits HI/LO after a fixed latency.
// Define MDU_MADD_EN to make MADD/MADDU/MSUB/MSUBU accumulate into HI/LO.
module md_seq_ctrl
   import md_pkg::*;
#(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input  logic         clk,
   input  logic         reset,
   md_seq_ctrl_if.slave md
);

   logic [31:0]         hi_q, lo_q;
   logic [31:0]         ph, pl;
   logic                p_div0;
   logic [63:0]         pend_n;
   logic                div0_n;
   logic [MD_CNT_W-1:0] lat;
   logic                busy, done, start;

   logic [63:0] prod_s, prod_u;
   logic        is_div_s;
   logic [31:0] a_mag, b_mag, dvd, dvs, q_u, r_u, q, r;

   // Low 64 bits of the sign-extended product equal the signed 32x32 product.
   assign prod_s = {{32{md.rs_val[31]}}, md.rs_val} * {{32{md.rt_val[31]}}, md.rt_val};
   assign prod_u = {32'd0, md.rs_val} * {32'd0, md.rt_val};

   // One unsigned divider serves both DIV and DIVU; signed results are fixed up afterwards.
   assign is_div_s = (md.md_op == MD_DIV);
   assign a_mag    = md.rs_val[31] ? (32'd0 - md.rs_val) : md.rs_val;
   assign b_mag    = md.rt_val[31] ? (32'd0 - md.rt_val) : md.rt_val;
   assign dvd      = is_div_s ? a_mag : md.rs_val;
   assign dvs      = (md.rt_val == 32'd0) ? 32'd1 : (is_div_s ? b_mag : md.rt_val);
   assign q_u      = dvd / dvs;
   assign r_u      = dvd % dvs;
   assign q        = (is_div_s && (md.rs_val[31] ^ md.rt_val[31])) ? (32'd0 - q_u) : q_u;
   assign r        = (is_div_s && md.rs_val[31]) ? (32'd0 - r_u) : r_u;

   always_comb begin
      pend_n = {ph, pl};
      div0_n = 1'b0;
      lat    = '0;
      case (md.md_op)
         MD_MULT:  begin pend_n = prod_s; lat = MD_CNT_W'(MULT_LAT); end
         MD_MULTU: begin pend_n = prod_u; lat = MD_CNT_W'(MULT_LAT); end
         MD_DIV, MD_DIVU: begin
            pend_n = {r, q};
            div0_n = (md.rt_val == 32'd0);
            lat    = MD_CNT_W'(DIV_LAT);
         end
`ifdef MDU_MADD_EN
         MD_MADD:  begin pend_n = {hi_q, lo_q} + prod_s; lat = MD_CNT_W'(MULT_LAT); end
         MD_MADDU: begin pend_n = {hi_q, lo_q} + prod_u; lat = MD_CNT_W'(MULT_LAT); end
         MD_MSUB:  begin pend_n = {hi_q, lo_q} - prod_s; lat = MD_CNT_W'(MULT_LAT); end
         MD_MSUBU: begin pend_n = {hi_q, lo_q} - prod_u; lat = MD_CNT_W'(MULT_LAT); end
`endif
         default: ;
      endcase
   end

   assign start = md.e_valid & is_md_start(md.md_op) & ~busy;

   md_latency_cnt u_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (start),
      .load_val (lat),
      .busy     (busy),
      .done     (done)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         hi_q   <= '0;
         lo_q   <= '0;
         ph     <= '0;
         pl     <= '0;
         p_div0 <= 1'b0;
      end else begin
         if (start) begin
            {ph, pl} <= pend_n;
            p_div0   <= div0_n;
         end
         if (done) begin
            if (!p_div0) begin
               hi_q <= ph;
               lo_q <= pl;
            end
         end else if (md.e_valid && !busy) begin
            if (md.md_op == MD_MTHI)
               hi_q <= md.rs_val;
            else if (md.md_op == MD_MTLO)
               lo_q <= md.rs_val;
         end
      end
   end

   assign md.start    = start;
   assign md.busy     = busy;
   assign md.md_stall = md.d_uses_md & (start | busy);
   assign md.hi       = hi_q;
   assign md.lo       = lo_q;

   // The hazard unit must keep MD ops out of E while a computation is in flight.
   a_no_md_op_while_busy: assert property (@(posedge clk) disable iff (reset)
      !(md.e_valid && busy &&
        (is_md_start(md.md_op) || md.md_op == MD_MTHI || md.md_op == MD_MTLO)));

endmodule

// File: tb/tb_md_seq_ctrl.sv
// Directed bench for md_seq_ctrl with hand-computed HI/LO and timing expectations.
// Define MDU_MADD_EN to exercise the accumulate opcodes.
module tb_md_seq_ctrl;
   import md_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;

   md_seq_ctrl_if md ();

   md_seq_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
      .clk   (clk),
      .reset (reset),
      .md    (md.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic ev, input md_op_t op, input logic [31:0] a, input logic [31:0] b);
      md.e_valid = ev;
      md.md_op   = op;
      md.rs_val  = a;
      md.rt_val  = b;
      #1;
   endtask

   task automatic idle();
      drive(1'b0, MD_NONE, 32'd0, 32'd0);
   endtask

   // Walk n busy cycles; HI/LO must hold their pre-commit values throughout.
   task automatic run_busy(input int n, input logic stall_exp,
                           input logic [31:0] hi_hold, input logic [31:0] lo_hold);
      for (int i = 0; i < n; i++) begin
         chk("busy", 64'(md.busy), 64'd1);
         chk("stall_busy", 64'(md.md_stall), 64'(stall_exp));
         chk("hi_hold", 64'(md.hi), 64'(hi_hold));
         chk("lo_hold", 64'(md.lo), 64'(lo_hold));
         tick();
      end
   endtask

   task automatic issue(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
      drive(1'b1, op, a, b);
      chk("start", 64'(md.start), 64'd1);
      tick();
      idle();
   endtask

   task automatic result(input string tag, input logic [31:0] hi_exp, input logic [31:0] lo_exp);
      chk({tag, "_busy_low"}, 64'(md.busy), 64'd0);
      chk({tag, "_hi"}, 64'(md.hi), 64'(hi_exp));
      chk({tag, "_lo"}, 64'(md.lo), 64'(lo_exp));
   endtask

   initial begin
      reset        = 1'b1;
      md.d_uses_md = 1'b0;
      idle();
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("rst_hi", 64'(md.hi), 64'd0);
      chk("rst_lo", 64'(md.lo), 64'd0);
      chk("rst_busy", 64'(md.busy), 64'd0);
      chk("rst_start", 64'(md.start), 64'd0);

      // MULT -2*3 with mflo waiting in D: stall for start cycle plus 5 busy cycles.
      md.d_uses_md = 1'b1;
      drive(1'b1, MD_MULT, 32'hFFFF_FFFE, 32'd3);
      chk("mult_stall_start", 64'(md.md_stall), 64'd1);
      issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
      run_busy(5, 1'b1, 32'd0, 32'd0);
      chk("mult_stall_release", 64'(md.md_stall), 64'd0);
      result("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      md.d_uses_md = 1'b0;

      issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
      run_busy(10, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      result("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

      // Back-to-back: DIVU issued in the first non-busy cycle.
      issue(MD_DIVU, 32'd7, 32'd2);
      run_busy(10, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      result("divu", 32'd1, 32'd3);

      issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_busy(5, 1'b0, 32'd1, 32'd3);
      result("multu", 32'hFFFF_FFFE, 32'd1);

      issue(MD_DIV, 32'd7, 32'hFFFF_FFFE);
      run_busy(10, 1'b0, 32'hFFFF_FFFE, 32'd1);
      result("div_negdvs", 32'd1, 32'hFFFF_FFFD);

      // Reset on the third busy cycle of a DIV discards the pending result.
      issue(MD_DIV, 32'd100, 32'd7);
      run_busy(2, 1'b0, 32'd1, 32'hFFFF_FFFD);
      reset = 1'b1;
      #1;
      tick();
      result("div_reset", 32'd0, 32'd0);
      reset = 1'b0;
      repeat (12) tick();
      result("div_reset_late", 32'd0, 32'd0);

      // MTHI/MTLO write on the next edge; no start and no stall.
      md.d_uses_md = 1'b1;
      drive(1'b1, MD_MTHI, 32'h1234_5678, 32'd0);
      chk("mthi_start", 64'(md.start), 64'd0);
      chk("mthi_stall", 64'(md.md_stall), 64'd0);
      tick();
      md.d_uses_md = 1'b0;
      chk("mthi_hi", 64'(md.hi), 64'h1234_5678);
      drive(1'b1, MD_MTLO, 32'hCAFE_F00D, 32'd0);
      tick();
      idle();
      chk("mtlo_lo", 64'(md.lo), 64'hCAFE_F00D);
      chk("mtlo_busy", 64'(md.busy), 64'd0);

      issue(MD_DIV, 32'd5, 32'd0);
      run_busy(10, 1'b0, 32'h1234_5678, 32'hCAFE_F00D);
      result("div0", 32'h1234_5678, 32'hCAFE_F00D);

      drive(1'b1, MD_MTHI, 32'd0, 32'd0);
      tick();
      drive(1'b1, MD_MTLO, 32'd5, 32'd0);
      tick();
      idle();
`ifdef MDU_MADD_EN
      issue(MD_MADD, 32'd3, 32'd4);
      run_busy(5, 1'b0, 32'd0, 32'd5);
      result("madd", 32'd0, 32'd17);
`else
      drive(1'b1, MD_MADD, 32'd3, 32'd4);
      chk("madd_off_start", 64'(md.start), 64'd0);
      tick();
      idle();
      chk("madd_off_busy", 64'(md.busy), 64'd0);
      repeat (6) tick();
      result("madd_off", 32'd0, 32'd5);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
